shrimp_program_counter: RTL and testbench

Parametrised program counter for the shrimp CPU fetch stage. Holds the current instruction address and advances it by a fixed step each clock. It also supports absolute jumps, PC-relative branches, stalls, and call/return through an internal return-address stack. The decoder/branch unit drives it, and its address output feeds instruction memory directly.

---
 rtl/shrimp_program_counter.sv | 173 +++++++++++++++++
 tb/tb_shrimp_program_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shrimp_program_counter.sv
// ---------------------------------------------------------------------------
// shrimp_program_counter
//
// Program counter for the shrimp CPU fetch stage. It holds the address of the
// instruction being fetched and moves it forward by STEP bytes every clock.
// It can also do absolute jumps, PC-relative branches, stalls, and
// call/return through a small internal return-address stack.
//
// Parameters
//   ADDR_WIDTH  : width of all addresses and offsets
//   STEP        : bytes per instruction (power of two, >= 1)
//   STACK_DEPTH : number of return-address stack entries (>= 1)
//   RESET_ADDR  : address loaded on reset (STEP-aligned)
//
// Ports
//   clock               : single clock, rising edge
//   reset               : asynchronous, active-high reset
//   stall               : hold every piece of state this cycle
//   jump / jump_addr    : absolute jump; jump_addr is also the call target
//   branch              : address <= address + branch_offset (signed)
//   branch_offset       : two's-complement byte offset
//   call                : jump to jump_addr and push address + STEP
//   ret                 : pop the top of the stack into the address
//   clear_errors        : clear the sticky error flags
//   instruction_address : address of the instruction to fetch (registered)
//   stack_count         : number of valid stack entries (registered)
//   stack_full/empty    : decoded from the stack_count register
//   overflow_err        : sticky; a call was attempted while the stack was full
//   underflow_err       : sticky; a ret was attempted while the stack was empty
// ---------------------------------------------------------------------------
module shrimp_program_counter #(
  parameter int unsigned            ADDR_WIDTH  = 16,
  parameter int unsigned            STEP        = 2,
  parameter int unsigned            STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR  = '0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   stall,
  input  logic                                   jump,
  input  logic [ADDR_WIDTH-1:0]                  jump_addr,
  input  logic                                   branch,
  input  logic [ADDR_WIDTH-1:0]                  branch_offset,
  input  logic                                   call,
  input  logic                                   ret,
  input  logic                                   clear_errors,
  output logic [ADDR_WIDTH-1:0]                  instruction_address,
  output logic [$clog2(STACK_DEPTH+1)-1:0]       stack_count,
  output logic                                   stack_full,
  output logic                                   stack_empty,
  output logic                                   overflow_err,
  output logic                                   underflow_err
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // STEP is a power of two, so STEP-1 is exactly the set of low bits that
  // must be zero in any loaded target.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STEP - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP_INC   = ADDR_WIDTH'(STEP);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

  // Architectural state
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  // Return-address storage; entries at or above count_q are don't-care
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  // Helpers for the next-state logic
  logic [ADDR_WIDTH-1:0] seqAddr;
  logic [ADDR_WIDTH-1:0] jumpTarget;
  logic [ADDR_WIDTH-1:0] branchTarget;
  logic [ADDR_WIDTH-1:0] popAddr;
  logic [PTR_W-1:0]      pushIdx;
  logic [PTR_W-1:0]      popIdx;
  logic                  isFull;
  logic                  isEmpty;
  logic                  pushEn;

  assign isFull  = (count_q == CNT_FULL);
  assign isEmpty = (count_q == '0);

  // Target computation. branch_offset already has ADDR_WIDTH bits, so a
  // same-width modular add is identical to adding the sign-extended offset.
  assign seqAddr      = addr_q + STEP_INC;
  assign jumpTarget   = jump_addr & ALIGN_MASK;
  assign branchTarget = (addr_q + branch_offset) & ALIGN_MASK;

  // The top of the stack lives at index count-1; a push writes index count.
  assign pushIdx = PTR_W'(count_q);
  assign popIdx  = PTR_W'(count_q - CNT_ONE);
  assign popAddr = stack_q[popIdx] & ALIGN_MASK;

  // Next-state selection. The if/else chain encodes request priority
  // (stall, ret, call, jump, branch, increment) so only the winning request
  // has any effect. clear_errors is applied first so that an error raised in
  // the same cycle overrides it and leaves the flag set.
  always_comb begin
    addr_d      = addr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    pushEn      = 1'b0;

    if (!stall) begin
      if (clear_errors) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end

      if (ret) begin
        if (isEmpty) begin
          addr_d      = seqAddr;
          underflow_d = 1'b1;
        end else begin
          addr_d  = popAddr;
          count_d = count_q - CNT_ONE;
        end
      end else if (call) begin
        addr_d = jumpTarget;
        if (isFull) begin
          overflow_d = 1'b1;
        end else begin
          pushEn  = 1'b1;
          count_d = count_q + CNT_ONE;
        end
      end else if (jump) begin
        addr_d = jumpTarget;
      end else if (branch) begin
        addr_d = branchTarget;
      end else begin
        addr_d = seqAddr;
      end
    end
  end

  // Control state with asynchronous reset; reset empties the stack by
  // zeroing the count, which discards whatever the storage holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q      <= RESET_ADDR;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack storage needs no reset since its contents only matter below the
  // count. The push data is the return address, i.e. the sequential address.
  always_ff @(posedge clock) begin
    if (pushEn && !reset) begin
      stack_q[pushIdx] <= seqAddr;
    end
  end

  assign instruction_address = addr_q;
  assign stack_count         = count_q;
  assign stack_full          = isFull;
  assign stack_empty         = isEmpty;
  assign overflow_err        = overflow_q;
  assign underflow_err       = underflow_q;

endmodule

// File: tb/tb_shrimp_program_counter.sv
// ---------------------------------------------------------------------------
// tb_shrimp_program_counter
//
// Self-checking bench for shrimp_program_counter with ADDR_WIDTH=16, STEP=2,
// STACK_DEPTH=4, RESET_ADDR=0. Directed vectors push hand-computed expected
// state into a scoreboard queue; a monitor pops one entry after every rising
// edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_shrimp_program_counter;

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  cnt;
    logic        ovf;
    logic        udf;
    string       name;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [15:0] jump_addr;
  logic        branch;
  logic [15:0] branch_offset;
  logic        call;
  logic        ret;
  logic        clear_errors;
  logic [15:0] instruction_address;
  logic [2:0]  stack_count;
  logic        stack_full;
  logic        stack_empty;
  logic        overflow_err;
  logic        underflow_err;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t scoreboard[$];

  shrimp_program_counter #(
    .ADDR_WIDTH (16),
    .STEP       (2),
    .STACK_DEPTH(4),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .jump               (jump),
    .jump_addr          (jump_addr),
    .branch             (branch),
    .branch_offset      (branch_offset),
    .call               (call),
    .ret                (ret),
    .clear_errors       (clear_errors),
    .instruction_address(instruction_address),
    .stack_count        (stack_count),
    .stack_full         (stack_full),
    .stack_empty        (stack_empty),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare every output against one expected entry; full/empty follow from
  // the expected count.
  task automatic checkOutput(input exp_t e);
    logic eFull;
    logic eEmpty;
    eFull  = (e.cnt == 3'd4);
    eEmpty = (e.cnt == 3'd0);
    compared++;
    if (instruction_address !== e.addr || stack_count !== e.cnt ||
        stack_full !== eFull || stack_empty !== eEmpty ||
        overflow_err !== e.ovf || underflow_err !== e.udf) begin
      mismatched++;
      $display("[TB] FAIL %s: got addr=%h cnt=%0d full=%b empty=%b ovf=%b udf=%b, want addr=%h cnt=%0d full=%b empty=%b ovf=%b udf=%b",
               e.name, instruction_address, stack_count, stack_full, stack_empty,
               overflow_err, underflow_err, e.addr, e.cnt, eFull, eEmpty, e.ovf, e.udf);
    end
  endtask

  // Drive one cycle of requests and queue the state expected after the edge
  task automatic applyStimulus(input logic s, input logic r, input logic c,
                               input logic j, input logic b, input logic clr,
                               input logic [15:0] ja, input logic [15:0] bo,
                               input logic [15:0] eAddr, input logic [2:0] eCnt,
                               input logic eOvf, input logic eUdf,
                               input string name);
    exp_t e;
    stall         = s;
    ret           = r;
    call          = c;
    jump          = j;
    branch        = b;
    clear_errors  = clr;
    jump_addr     = ja;
    branch_offset = bo;
    e.addr = eAddr;
    e.cnt  = eCnt;
    e.ovf  = eOvf;
    e.udf  = eUdf;
    e.name = name;
    scoreboard.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkNow(input logic [15:0] eAddr, input logic [2:0] eCnt,
                          input logic eOvf, input logic eUdf, input string name);
    exp_t e;
    e.addr = eAddr;
    e.cnt  = eCnt;
    e.ovf  = eOvf;
    e.udf  = eUdf;
    e.name = name;
    checkOutput(e);
  endtask

  // Monitor: one expected entry per rising edge, sampled just after it
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (scoreboard.size() != 0) checkOutput(scoreboard.pop_front());
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want end of stimulus");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0; call = 1'b0;
    ret = 1'b0; clear_errors = 1'b0; jump_addr = '0; branch_offset = '0;

    // Reset pulse between edges takes effect without a clock
    #2 reset = 1'b1;
    #1 checkNow(16'h0000, 3'd0, 1'b0, 1'b0, "asyncResetInit");
    @(negedge clock);
    reset = 1'b0;

    //               st r  c  j  b  clr jump_addr  offset    addr      cnt ovf udf
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd2,    3'd0, 0, 0, "inc1");
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd4,    3'd0, 0, 0, "inc2");
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd6,    3'd0, 0, 0, "inc3");
    applyStimulus(0, 0, 0, 1, 0, 0, 16'd120,  16'h0000, 16'd120,  3'd0, 0, 0, "jump120");
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'hFFF8, 16'd112,  3'd0, 0, 0, "branchBack");
    applyStimulus(0, 0, 0, 1, 1, 0, 16'd40,   16'hFFF8, 16'd40,   3'd0, 0, 0, "jumpOverBranch");
    applyStimulus(1, 0, 0, 1, 0, 0, 16'd100,  16'h0000, 16'd40,   3'd0, 0, 0, "stallHolds");
    applyStimulus(0, 0, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFE, 3'd0, 0, 0, "jumpAlign");
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0, 0, "incWrap");
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'hFFFC, 16'hFFFC, 3'd0, 0, 0, "branchWrap");

    // Call/return nesting
    applyStimulus(0, 0, 0, 1, 0, 0, 16'd10,   16'h0000, 16'd10,   3'd0, 0, 0, "jump10");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'd100,  16'h0000, 16'd100,  3'd1, 0, 0, "call100");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'd200,  16'h0000, 16'd200,  3'd2, 0, 0, "call200");
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd102,  3'd1, 0, 0, "ret102");
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd12,   3'd0, 0, 0, "ret12");

    // Overflow: four pushes of 14, 0x402, 0x502, 0x602 then a fifth call
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h0400, 16'h0000, 16'h0400, 3'd1, 0, 0, "fill1");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h0500, 16'h0000, 16'h0500, 3'd2, 0, 0, "fill2");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h0600, 16'h0000, 16'h0600, 3'd3, 0, 0, "fill3");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h0700, 16'h0000, 16'h0700, 3'd4, 0, 0, "fill4");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'd300,  16'h0000, 16'd300,  3'd4, 1, 0, "callOverflow");
    applyStimulus(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'd300,  3'd4, 1, 0, "stallIgnoresClear");
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0602, 3'd3, 1, 0, "pop602");
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0502, 3'd2, 1, 0, "pop502");
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0402, 3'd1, 1, 0, "pop402");
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd14,   3'd0, 1, 0, "pop14");
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'd16,   3'd0, 0, 0, "clearOverflow");

    // Underflow and clear/error collision
    applyStimulus(0, 0, 0, 1, 0, 0, 16'd50,   16'h0000, 16'd50,   3'd0, 0, 0, "jump50");
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd52,   3'd0, 0, 1, "retUnderflow");
    applyStimulus(0, 1, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'd54,   3'd0, 0, 1, "errorBeatsClear");
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'd56,   3'd0, 0, 0, "clearUnderflow");

    // ret and call together with [80] on the stack
    applyStimulus(0, 0, 0, 1, 0, 0, 16'd78,   16'h0000, 16'd78,   3'd0, 0, 0, "jump78");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'd500,  16'h0000, 16'd500,  3'd1, 0, 0, "push80");
    applyStimulus(0, 1, 1, 0, 0, 0, 16'd900,  16'h0000, 16'd80,   3'd0, 0, 0, "retBeatsCall");
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd82,   3'd0, 0, 1, "noPushFromCall");
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'd84,   3'd0, 0, 0, "clearAgain");
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0006, 16'd90,   3'd0, 0, 0, "branchFwd");

    // Build up count=3 with an error flag, then reset asynchronously
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd92,   3'd0, 0, 1, "retUnderflow2");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h1001, 16'h0000, 16'h1000, 3'd1, 0, 1, "callAlign");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h2000, 16'h0000, 16'h2000, 3'd2, 0, 1, "call2000");
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h3000, 16'h0000, 16'h3000, 3'd3, 0, 1, "call3000");

    #2;
    reset     = 1'b1;
    jump      = 1'b1;
    jump_addr = 16'h0044;
    #1 checkNow(16'h0000, 3'd0, 1'b0, 1'b0, "asyncResetMid");
    @(posedge clock);
    #1 checkNow(16'h0000, 3'd0, 1'b0, 1'b0, "resetIgnoresEdge");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd2,    3'd0, 0, 0, "incAfterReset");
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'd4,    3'd0, 0, 1, "stackDiscarded");

    // Every queued expectation must have been consumed by the monitor
    repeat (3) @(negedge clock);
    compared++;
    if (scoreboard.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, want 0", scoreboard.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
